divisor_feeder: RTL and testbench



---
 rtl/divisor_pkg.sv | 25 ++
 rtl/divisor_req_fifo.sv | 49 ++++
 rtl/divisor_feeder.sv | 123 ++++++++++++
 tb/tb_divisor_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// divisor_pkg: shared types for the divider request feeder
package divisor_pkg;
    localparam int W_DATA = 32;
    localparam int W_TAG  = 4;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIV0    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVF     = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [W_DATA-1:0] num;
        logic [W_DATA-1:0] den;
        logic [W_TAG-1:0]  tag;
    } req_t;
endpackage

// File: rtl/divisor_req_fifo.sv
// divisor_req_fifo: request FIFO with the head visible combinationally
module divisor_req_fifo
    import divisor_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  req_t        i_data,
    output req_t        o_head,
    output logic [AW:0] o_count,
    output logic        o_full,
    output logic        o_empty
);
    req_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/divisor_feeder.sv
// divisor_feeder: queues signed divide requests, filters div0/overflow,
// drives the iterative divider and returns tagged results with an error code
module divisor_feeder
    import divisor_pkg::*;
#(
    parameter int tamanyo = W_DATA,
    parameter int TAG_W   = W_TAG,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 72
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [tamanyo-1:0]      in_num,
    input  logic [tamanyo-1:0]      in_den,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    div_start,
    output logic [tamanyo-1:0]      div_num,
    output logic [tamanyo-1:0]      div_den,
    input  logic [tamanyo-1:0]      div_coc,
    input  logic [tamanyo-1:0]      div_res,
    input  logic                    div_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [tamanyo-1:0]      out_coc,
    output logic [tamanyo-1:0]      out_res,
    output logic [TAG_W-1:0]        out_tag,
    output logic [1:0]              out_err,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int                 TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]      T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [tamanyo-1:0] MOST_NEG = {1'b1, {(tamanyo-1){1'b0}}};

    state_t        r_state;
    logic [TW-1:0] r_timer;
    req_t          w_in;
    req_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    assign w_in     = '{num: in_num, den: in_den, tag: in_tag};
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign in_ready = !w_full;

    divisor_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (in_valid && in_ready),
        .i_pop   (w_pop),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            div_start <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            out_valid <= 1'b0;
            out_coc   <= '0;
            out_res   <= '0;
            out_tag   <= '0;
            out_err   <= ERR_OK;
        end else begin
            div_start <= 1'b0;
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    out_tag <= w_head.tag;
                    if (w_head.den == '0) begin
                        out_coc   <= '0;
                        out_res   <= w_head.num;
                        out_err   <= ERR_DIV0;
                        out_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else if (w_head.num == MOST_NEG && w_head.den == '1) begin
                        out_coc   <= w_head.num;
                        out_res   <= '0;
                        out_err   <= ERR_OVF;
                        out_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        div_num   <= w_head.num;
                        div_den   <= w_head.den;
                        div_start <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (div_done) begin
                    out_coc   <= div_coc;
                    out_res   <= div_res;
                    out_err   <= ERR_OK;
                    out_valid <= 1'b1;
                    r_state   <= S_HOLD;
                end else if (r_timer == T_LAST) begin
                    out_coc   <= '0;
                    out_res   <= '0;
                    out_err   <= ERR_TIMEOUT;
                    out_valid <= 1'b1;
                    r_state   <= S_HOLD;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
                S_HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_feeder.sv
// tb_divisor_feeder: directed checks of the feeder against a stub divider
module tb_divisor_feeder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_num = '0;
    logic [31:0] in_den = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, div_start, div_done, out_valid;
    logic [31:0] div_num, div_den, div_coc, div_res, out_coc, out_res;
    logic [3:0]  out_tag;
    logic [1:0]  out_err;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_start = 0;
    int done_cyc = -100;
    int gap_viol = 0;
    int scnt = 0;
    logic [31:0] last_num = '0;
    logic [31:0] last_den = '0;
    logic hang = 1'b0;
    logic inj = 1'b0;

    logic [31:0] nums [5] = '{-32'sd100, 32'sd50, -32'sd9, 32'sd7, 32'sd3};
    logic [31:0] dens [5] = '{32'sd7, -32'sd6, -32'sd4, 32'sd7, 32'sd10};
    logic [31:0] cocs [5] = '{-32'sd14, -32'sd8, 32'sd2, 32'sd1, 32'sd0};
    logic [31:0] ress [5] = '{-32'sd2, 32'sd2, -32'sd1, 32'sd0, 32'sd3};

    always #5 CLK = ~CLK;

    divisor_feeder dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_coc(out_coc), .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
        .count(count)
    );

    // Stub divider: Done pulses 66 cycles after the edge that samples Start.
    always @(posedge CLK) begin
        if (RST) begin
            scnt     <= 0;
            div_done <= 1'b0;
        end else begin
            div_done <= (scnt == 1 && !hang) || inj;
            scnt     <= div_start ? 66 : (scnt > 0 ? scnt - 1 : 0);
            if (div_start) begin
                div_coc <= $signed(div_num) / $signed(div_den);
                div_res <= $signed(div_num) % $signed(div_den);
            end
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (div_start) begin
            n_start  <= n_start + 1;
            last_num <= div_num;
            last_den <= div_den;
            if (cyc - done_cyc < 3)
                gap_viol <= gap_viol + 1;
        end
        if (div_done)
            done_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] n, input logic [31:0] d, input logic [3:0] t);
        int w = 0;
        in_valid = 1'b1;
        in_num = n;
        in_den = d;
        in_tag = t;
        while (!in_ready && w < 500) begin
            @(posedge CLK); #1;
            w++;
        end
        chk("push_wait", 32'(w < 500), 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("out_wait", 32'(out_valid), 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        logic ok;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_start", 32'(div_start), 0);
        chk("rst_err", 32'(out_err), 0);

        s0 = n_start;
        push(100, 7, 3);
        wait_out(n);
        chk("div_lat", n, 69);
        chk("div_starts", n_start - s0, 1);
        chk("div_num", last_num, 100);
        chk("div_den", last_den, 7);
        chk("div_coc", out_coc, 14);
        chk("div_res", out_res, 2);
        chk("div_tag", 32'(out_tag), 3);
        chk("div_err", 32'(out_err), 0);
        consume();
        chk("pop_valid", 32'(out_valid), 0);

        s0 = n_start;
        push(32'hFFFF_FFFB, 0, 5);
        wait_out(n);
        chk("div0_lat", 32'(n <= 2), 1);
        chk("div0_coc", out_coc, 0);
        chk("div0_res", out_res, 32'hFFFF_FFFB);
        chk("div0_err", 32'(out_err), 1);
        chk("div0_tag", 32'(out_tag), 5);
        chk("div0_nostart", n_start - s0, 0);
        consume();

        s0 = n_start;
        push(32'h8000_0000, 32'hFFFF_FFFF, 6);
        wait_out(n);
        chk("ovf_lat", 32'(n <= 2), 1);
        chk("ovf_coc", out_coc, 32'h8000_0000);
        chk("ovf_res", out_res, 0);
        chk("ovf_err", 32'(out_err), 3);
        chk("ovf_nostart", n_start - s0, 0);
        consume();

        out_ready = 1'b1;
        s0 = n_start;
        for (int i = 0; i < 5; i++)
            push(nums[i], dens[i], 4'(i));
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            wait_out(n);
            chk("seq_tag", 32'(out_tag), i);
            chk("seq_coc", out_coc, cocs[i]);
            chk("seq_res", out_res, ress[i]);
            chk("seq_err", 32'(out_err), 0);
            @(posedge CLK); #1;
            if (i == 0) begin
                @(posedge CLK); #1;
                chk("ready_back", 32'(in_ready), 1);
            end
        end
        chk("seq_starts", n_start - s0, 5);
        chk("start_gap", gap_viol, 0);
        out_ready = 1'b0;

        hang = 1'b1;
        s0 = n_start;
        push(40, 5, 8);
        wait_out(n);
        chk("tmo_lat", n, 74);
        chk("tmo_err", 32'(out_err), 2);
        chk("tmo_coc", out_coc, 0);
        chk("tmo_tag", 32'(out_tag), 8);
        inj = 1'b1;
        @(posedge CLK); #1;
        inj = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("late_valid", 32'(out_valid), 1);
        chk("late_err", 32'(out_err), 2);
        chk("late_coc", out_coc, 0);
        hang = 1'b0;
        consume();
        push(40, 5, 9);
        wait_out(n);
        chk("after_coc", out_coc, 8);
        chk("after_err", 32'(out_err), 0);
        chk("after_tag", 32'(out_tag), 9);
        chk("after_starts", n_start - s0, 2);
        consume();

        push(1000, 10, 10);
        wait_out(n);
        push(6, 3, 11);
        s0 = n_start;
        ok = 1'b1;
        repeat (20) begin
            @(posedge CLK); #1;
            if (out_valid !== 1'b1 || out_coc !== 32'd100 || out_res !== 32'd0 ||
                out_tag !== 4'd10 || out_err !== 2'd0)
                ok = 1'b0;
        end
        chk("hold_stable", 32'(ok), 1);
        chk("hold_nostart", n_start - s0, 0);
        chk("hold_count", 32'(count), 1);
        consume();
        repeat (10) @(posedge CLK);
        #1;
        push(9, 2, 12);
        chk("pre_rst_count", 32'(count), 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        ok = 1'b1;
        repeat (80) begin
            @(posedge CLK); #1;
            if (out_valid !== 1'b0)
                ok = 1'b0;
        end
        chk("abandoned", 32'(ok), 1);
        push(9, 2, 12);
        wait_out(n);
        chk("post_rst_coc", out_coc, 4);
        chk("post_rst_res", out_res, 1);
        chk("post_rst_tag", 32'(out_tag), 12);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
